// File: rtl/sample_capture_buffer.sv
// sample_capture_buffer
// Records decimated snapshots of CHANNELS parallel samples into on-chip RAM
// after an arm pulse. It then streams the stored snapshots out one channel
// per beat over a valid/ready port, in entry order.
// Optional feature macro: CAP_TRIGGER_EN. When it is defined, capture waits
// for signed ch0 >= threshold, and the triggering sample is stored first.
module sample_capture_buffer #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 256,
  parameter int DECIM_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic                      sample_valid,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [DECIM_W-1:0]        decim,
  input  logic [WIDTH-1:0]          threshold,
  input  logic                      rd_start,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      rd_last,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = CHANNELS * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_DONE,
    S_READOUT
  } state_t;

  state_t               state;
  logic [SW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        rd_ch;
  logic                 iss_done;
  logic [DECIM_W-1:0]   decim_cnt;
  logic [DECIM_W-1:0]   decim_lat;
  logic [SW-1:0]        ram_q;
  logic                 ram_q_valid;
  logic                 ram_q_last;
  logic [CW-1:0]        ram_q_ch;

  logic cap_write;
  logic trig_write;
  logic mem_we;
  logic out_load;
  logic rd_en;
  logic rd_beat_last;

  // A decimated write in CAPTURE happens on the valid sample where the counter is at zero.
  assign cap_write = (state == S_CAPTURE) && sample_valid && (decim_cnt == '0);

`ifdef CAP_TRIGGER_EN
  logic trig_hit;
  assign trig_hit   = sample_valid && ($signed(sample_in[WIDTH-1:0]) >= $signed(threshold));
  assign trig_write = (state == S_WAIT_TRIG) && trig_hit;
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign trig_write       = 1'b0;
`endif

  assign mem_we = !rst && !abort && (cap_write || trig_write);

  // ram_q acts as the one-word skid. It moves to the output register whenever
  // that register is empty or is being drained this cycle.
  assign out_load = ram_q_valid && (!rd_valid || rd_ready);

  // Issue the next beat's read only when ram_q will be free after this edge.
  // This sustains one beat per cycle.
  assign rd_en = (state == S_READOUT) && !iss_done && (!ram_q_valid || out_load);

  assign rd_beat_last = (rd_ptr == AW'(DEPTH - 1)) && (rd_ch == CW'(CHANNELS - 1));

  // Capture RAM: synchronous write, and a registered read that holds when not enabled.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= sample_in;
    end
    if (rd_en) begin
      ram_q <= mem[rd_ptr];
    end
  end

  // Control FSM, the readout pipeline registers and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_ch       <= '0;
      iss_done    <= 1'b0;
      decim_cnt   <= '0;
      decim_lat   <= '0;
      ram_q_valid <= 1'b0;
      ram_q_last  <= 1'b0;
      ram_q_ch    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (out_load) begin
        rd_data  <= ram_q[ram_q_ch*WIDTH +: WIDTH];
        rd_valid <= 1'b1;
        rd_last  <= ram_q_last;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end

      if (rd_en) begin
        ram_q_valid <= 1'b1;
        ram_q_ch    <= rd_ch;
        ram_q_last  <= rd_beat_last;
      end else if (out_load) begin
        ram_q_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (arm) begin
            state     <= S_WAIT_TRIG;
            busy      <= 1'b1;
            decim_lat <= decim;
            decim_cnt <= '0;
            wr_ptr    <= '0;
          end
        end

        S_WAIT_TRIG: begin
`ifdef CAP_TRIGGER_EN
          // The triggering sample has already been written to entry 0.
          if (trig_hit) begin
            state     <= S_CAPTURE;
            wr_ptr    <= AW'(1);
            decim_cnt <= (decim_lat == '0) ? '0 : DECIM_W'(1);
          end
`else
          state <= S_CAPTURE;
`endif
        end

        S_CAPTURE: begin
          if (sample_valid) begin
            decim_cnt <= (decim_cnt == decim_lat) ? '0 : decim_cnt + DECIM_W'(1);
            if (decim_cnt == '0) begin
              wr_ptr <= wr_ptr + AW'(1);
              if (wr_ptr == AW'(DEPTH - 1)) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          if (rd_start) begin
            state    <= S_READOUT;
            busy     <= 1'b1;
            done     <= 1'b0;
            rd_ptr   <= '0;
            rd_ch    <= '0;
            iss_done <= 1'b0;
          end
        end

        S_READOUT: begin
          if (rd_en) begin
            if (rd_ch == CW'(CHANNELS - 1)) begin
              rd_ch  <= '0;
              rd_ptr <= rd_ptr + AW'(1);
            end else begin
              rd_ch <= rd_ch + CW'(1);
            end
            if (rd_beat_last) begin
              iss_done <= 1'b1;
            end
          end
          if (rd_valid && rd_ready && rd_last) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_ptr   <= '0;
            rd_ch    <= '0;
            iss_done <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// tb_sample_capture_buffer
// Table-driven capture/readout vectors, hand-written sequences, and
// randomized captures checked against a behavioural model. Build with
// CAP_TRIGGER_EN defined to also exercise the trigger feature.
module tb_sample_capture_buffer;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 4;
  localparam int DECIM_W  = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] sample_in;
  logic                      sample_valid;
  logic                      arm;
  logic                      abort;
  logic [DECIM_W-1:0]        decim;
  logic [WIDTH-1:0]          threshold;
  logic                      rd_start;
  logic [WIDTH-1:0]          rd_data;
  logic                      rd_valid;
  logic                      rd_ready;
  logic                      rd_last;
  logic                      busy;
  logic                      done;

  sample_capture_buffer #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .DECIM_W(DECIM_W)
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .abort(abort), .decim(decim), .threshold(threshold),
    .rd_start(rd_start), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int decim;
    int vstep;
    int ready_mode;
    int abort_at;
    int noise;
    int e0;
    int e1;
    int e2;
    int e3;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model_q [$];
  logic [31:0] beat_q [$];
  logic [31:0] thr_val;
  int          trig_list [9] = '{-200, 0, 50, 99, -200, 100, 150, 7, 300};

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arm, drive samples, and predict the stored snapshots into model_q.
  // mode 0: ramp ch0=base+n, ch1=-(base+n), n counting from the second edge after arm
  // mode 1: random data and random valid
  // mode 2: the trigger list
  task automatic capture(input int mode, input int d, input int vstep, input int base, input bit noise);
    int          j;
    int          n;
    int          vcnt;
    int          stored;
    bit          started;
    bit          v;
    logic [63:0] w;
    model_q.delete();
    decim = DECIM_W'(d);
    arm   = 1'b1;
    step();
    arm = 1'b0;
    check1("arm_busy", busy, 1'b1);
    check1("arm_done", done, 1'b0);
    j = 0; vcnt = 0; stored = 0; started = 1'b0;
    while (stored < DEPTH && j < 300) begin
      j++;
      v = 1'b0;
      w = '0;
      if (mode == 0) begin
        n = j - 2;
        if (j >= 2) v = ((n % vstep) == 0);
        w = {32'(-(base + n)), 32'(base + n)};
      end else if (mode == 1) begin
        v = ($urandom_range(0, 9) < 7);
        w = {$urandom, $urandom};
      end else if (j <= 9) begin
        v = 1'b1;
        w = {32'(-trig_list[j-1]), 32'(trig_list[j-1])};
      end
      sample_valid = v;
      sample_in    = w;
      if (noise) begin
        arm      = ($urandom_range(0, 3) == 0);
        rd_start = ($urandom_range(0, 3) == 0);
        decim    = DECIM_W'($urandom);
      end
`ifdef CAP_TRIGGER_EN
      if (!started && v && ($signed(w[31:0]) >= $signed(thr_val))) started = 1'b1;
`else
      if (j >= 2) started = 1'b1;
`endif
      if (started && v) begin
        if ((vcnt % (d + 1)) == 0) begin
          model_q.push_back(w);
          stored++;
        end
        vcnt++;
      end
      step();
      check1("cap_done", done, stored == DEPTH);
      check1("cap_busy", busy, stored != DEPTH);
    end
    checki("cap_entries", stored, DEPTH);
    arm = 1'b0; rd_start = 1'b0; sample_valid = 1'b0;
    $display("capture mode=%0d decim=%0d edges=%0d entries=%0d", mode, d, j, stored);
  endtask

  // Start readout and check every beat against beat_q. Optionally abort after abort_at accepted beats.
  task automatic readout(input int ready_mode, input int abort_at);
    int          idx;
    int          cyc;
    int          total;
    bit          hold;
    logic [31:0] hold_data;
    logic        hold_last;
    total    = beat_q.size();
    rd_ready = 1'b0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    check1("rd_busy", busy, 1'b1);
    check1("rd_done_low", done, 1'b0);
    check1("rd_lat1", rd_valid, 1'b0);
    step();
    check1("rd_lat2", rd_valid, 1'b0);
    step();
    check1("rd_first", rd_valid, 1'b1);
    idx = 0; cyc = 0; hold = 1'b0; hold_data = '0; hold_last = 1'b0;
    while (idx < total && cyc < 200) begin
      if (abort_at >= 0 && idx == abort_at) break;
      if (hold) begin
        check1("stall_valid", rd_valid, 1'b1);
        checkw("stall_data", rd_data, hold_data);
        check1("stall_last", rd_last, hold_last);
      end
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((cyc % 3) == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      sample_valid = 1'($urandom_range(0, 1));
      sample_in    = {$urandom, $urandom};
      if (ready_mode == 0) check1("stream_valid", rd_valid, 1'b1);
      if (rd_valid && rd_ready) begin
        checkw("beat_data", rd_data, beat_q[idx]);
        check1("beat_last", rd_last, idx == total - 1);
        idx++;
        hold = 1'b0;
      end else if (rd_valid) begin
        hold      = 1'b1;
        hold_data = rd_data;
        hold_last = rd_last;
      end else begin
        hold = 1'b0;
      end
      step();
      cyc++;
    end
    sample_valid = 1'b0;
    if (abort_at >= 0) begin
      abort    = 1'b1;
      rd_ready = 1'b0;
      step();
      abort = 1'b0;
      checki("abort_beats", idx, abort_at);
      check1("abort_valid", rd_valid, 1'b0);
      check1("abort_busy", busy, 1'b0);
      check1("abort_done", done, 1'b0);
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      repeat (4) begin
        check1("idle_rdstart_valid", rd_valid, 1'b0);
        check1("idle_rdstart_busy", busy, 1'b0);
        step();
      end
    end else begin
      checki("readout_beats", idx, total);
      check1("end_valid", rd_valid, 1'b0);
      check1("end_busy", busy, 1'b0);
      check1("end_done", done, 1'b0);
    end
    rd_ready = 1'b0;
    $display("readout ready_mode=%0d beats=%0d of %0d cycles=%0d", ready_mode, idx, total, cyc);
  endtask

  task automatic load_beats(input int base, input int e0, input int e1, input int e2, input int e3);
    int ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    beat_q.delete();
    for (int k = 0; k < 4; k++) begin
      beat_q.push_back(32'(base + ev[k]));
      beat_q.push_back(32'(-(base + ev[k])));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // decim, vstep, ready_mode, abort_at, noise, stored ch0 values
    vecs[0] = '{0, 1, 0, -1, 0, 0, 1, 2, 3};
    vecs[1] = '{2, 1, 1, -1, 1, 0, 3, 6, 9};
    vecs[2] = '{1, 1, 2, -1, 0, 0, 2, 4, 6};
    vecs[3] = '{0, 2, 1, -1, 1, 0, 2, 4, 6};
    vecs[4] = '{1, 2, 0, -1, 0, 0, 4, 8, 12};
    vecs[5] = '{2, 3, 2, -1, 1, 0, 9, 18, 27};
    vecs[6] = '{0, 1, 0, 3, 0, 0, 1, 2, 3};

    rst = 1'b1; sample_in = '0; sample_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    decim = '0; threshold = '0; thr_val = '0; rd_start = 1'b0; rd_ready = 1'b0;
    step();
    step();
    check1("rst_valid", rd_valid, 1'b0);
    check1("rst_last", rd_last, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    checkw("rst_data", rd_data, 32'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      capture(0, vecs[i].decim, vecs[i].vstep, 0, vecs[i].noise != 0);
      load_beats(0, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
      readout(vecs[i].ready_mode, vecs[i].abort_at);
      $display("vector %0d decim=%0d vstep=%0d done", i, vecs[i].decim, vecs[i].vstep);
    end

    // Reset in the middle of a capture, two entries in
    decim = '0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    sample_valid = 1'b0;
    step();
    for (int n = 0; n < 2; n++) begin
      sample_valid = 1'b1;
      sample_in    = {32'(-n), 32'(n)};
      step();
    end
    check1("mid_busy", busy, 1'b1);
    rst = 1'b1;
    sample_valid = 1'b0;
    step();
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_done", done, 1'b0);
    check1("midrst_valid", rd_valid, 1'b0);
    rst = 1'b0;
    capture(0, 0, 1, 100, 1'b0);
    load_beats(100, 0, 1, 2, 3);
    readout(0, -1);
    $display("reset mid-capture sequence done");

`ifdef CAP_TRIGGER_EN
    thr_val = 32'd100;
    threshold = thr_val;
    capture(2, 0, 1, 0, 1'b0);
    beat_q.delete();
    beat_q.push_back(32'd100);  beat_q.push_back(-32'd100);
    beat_q.push_back(32'd150);  beat_q.push_back(-32'd150);
    beat_q.push_back(32'd7);    beat_q.push_back(-32'd7);
    beat_q.push_back(32'd300);  beat_q.push_back(-32'd300);
    readout(1, -1);
    $display("trigger sequence done");
`endif

    for (int r = 0; r < 6; r++) begin
      thr_val = 32'($urandom_range(0, 2000)) - 32'd1000;
      threshold = thr_val;
      capture(1, int'($urandom_range(0, 3)), 1, 0, 1'b1);
      beat_q.delete();
      foreach (model_q[k]) begin
        beat_q.push_back(model_q[k][31:0]);
        beat_q.push_back(model_q[k][63:32]);
      end
      readout(2, -1);
      $display("random run %0d done", r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
